uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter that responds to the picorv32 native memory bus (`mem_valid`/`mem_ready`) and serialises CPU-written bytes onto a 8N1 TX line. It sits beside the data RAM in the top level, decoded from its own 8-byte address window. It buffers bytes in a small FIFO so the CPU can issue back-to-back writes. It is the CPU-driven outbound counterpart of the UART program loader.

## Interface
- `ClkFreq`, 12000000, clock frequency in Hz
- `BaudRate`, 115200, line rate; `Div = ClkFreq / BaudRate` (integer floor, must be ≥ 2)
- `FifoDepth`, 8, TX FIFO entries, power of two, ≥ 2
- `BaseAddr`, 32'h0000_1000, window base, 8-byte aligned
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset, asynchronous, active-high
- `mem_valid_i`  in  1  bus request valid
- `mem_addr_i`  in  32  byte address
- `mem_wdata_i`  in  32  write data
- `mem_wstrb_i`  in  4  byte write strobes; 0 = read
- `mem_rdata_o`  out  32  read data, valid while `mem_ready_o` = 1
- `mem_ready_o`  out  1  one-cycle response pulse
- `tx_o`  out  1  serial line, idle high

## Operation
- Select: `sel = mem_valid_i && mem_addr_i[31:3] == BaseAddr[31:3]`. Unselected requests are ignored; `mem_ready_o` stays 0.
- Offset 0 (DATA):
  - A write with `mem_wstrb_i[0]` = 1 pushes `mem_wdata_i[7:0]`.
  - A write with `mem_wstrb_i[0]` = 0 is acknowledged without a push.
  - A read returns 0.
- Offset 4 (STATUS), read-only; writes are acknowledged and ignored.
  - bit0 = FIFO full, bit1 = FIFO empty, bit2 = TX busy (FSM not IDLE).
  - bits[$clog2(FifoDepth)+8:8] = FIFO count; all other bits 0.
- Accept rule: a selected request is accepted on an edge where `mem_ready_o` = 0.
  - A DATA write with `wstrb[0]` = 1 additionally requires count < FifoDepth.
  - When full, the write stalls with no ready and no push, and is accepted on the first edge after a pop frees space.
- TX FSM states and transitions:
  - IDLE: `tx_o` = 1. If the FIFO is not empty: pop, latch the byte, go to START.
  - START: `tx_o` = 0 for Div cycles, then go to DATA with bit index 0.
  - DATA: `tx_o` = byte[idx], LSB first, Div cycles per bit; after idx 7 go to STOP.
  - STOP: `tx_o` = 1 for Div cycles. On the last cycle, if the FIFO is not empty, pop and go to START directly (no idle gap); else go to IDLE.
- Baud counter: counts 0..Div-1 and is reset on every state entry; width `$clog2(Div)`.
- FIFO count arithmetic:
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo FifoDepth.

## Timing
- Reset values: `mem_ready_o` = 0, `mem_rdata_o` = 0, `tx_o` = 1, FSM = IDLE, FIFO empty, count 0, STATUS reads 32'h2.
- Reset mid-frame: `tx_o` returns high asynchronously and the partial frame is aborted; queued bytes are lost.
- Response latency: accept at edge N, so `mem_ready_o` = 1 and `mem_rdata_o` is valid for the cycle after edge N only.
- STATUS read value is sampled at the accept edge.
- Write-to-line latency, FIFO empty and FSM IDLE:
  - Push at edge N; pop at edge N+1; `tx_o` falls after edge N+1.
  - Frame length is 10·Div cycles.
- Back-to-back frames: the next START begins on the cycle after the STOP's last cycle.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_state_e` {IDLE, START, DATA, STOP}
  - register offsets `DataOff` = 0, `StatusOff` = 4
  - STATUS bit positions
- Sub-module `fifo_1r1w_sync`: parameterised width/depth, push/pop, full/empty/count. It is instantiated once with width 8.
- Bus decode, ready register, and TX FSM live in `uart_tx_mmio`.

## Test plan
- Reset, then read STATUS: `mem_ready_o` one cycle later with rdata 32'h2; `tx_o` = 1 throughout.
- Write 32'h55 to DATA with Div = 104:
  - `tx_o` low for 104 cycles, then bits 1,0,1,0,1,0,1,0, then high for 104.
  - Total 1040 cycles; STATUS bit2 is 1 during the frame.
- Write 10 bytes 0x00..0x09 back-to-back:
  - The first 9 are accepted one per two cycles (1 popped + 8 queued); the 10th stalls until the pop at the end of frame 0.
  - The frames are contiguous with no idle gap; the line decodes 0x00..0x09 in order.
- Write with `mem_wstrb_i` = 4'b0010 to DATA: acknowledged, count unchanged, no frame.
- Request outside the window (BaseAddr+8): no `mem_ready_o`, no state change.
- Assert `reset_i` mid-DATA of frame 2 with 3 bytes queued:
  - `tx_o` = 1 immediately; STATUS reads 32'h2 after release.
  - No further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
// Contents:
//   tx_state_e      TX FSM states
//   DataOff         byte offset of the DATA register
//   StatusOff       byte offset of the STATUS register
//   Stat*           bit positions inside the STATUS word
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [2:0] DataOff   = 3'd0;
  localparam logic [2:0] StatusOff = 3'd4;

  localparam int StatFullBit  = 0;
  localparam int StatEmptyBit = 1;
  localparam int StatBusyBit  = 2;
  localparam int StatCountLsb = 8;

endpackage

// File: rtl/fifo_1r1w_sync.sv
// rtl/fifo_1r1w_sync.sv - single-clock FIFO with push/pop and occupancy count
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   push_i, wdata_i   write request and data (ignored while full)
//   pop_i, rdata_o    read request; rdata_o shows the head entry combinationally
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (0..Depth)
module fifo_1r1w_sync #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - picorv32-bus UART transmitter (8N1) with TX FIFO
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   mem_valid_i      bus request valid
//   mem_addr_i       byte address; window is BaseAddr..BaseAddr+7
//   mem_wdata_i      write data; DATA pushes bits [7:0]
//   mem_wstrb_i      byte strobes; 0 means read
//   mem_rdata_o      read data, valid while mem_ready_o is high
//   mem_ready_o      one-cycle response pulse
//   tx_o             serial line, idle high
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          ClkFreq   = 12000000,
  parameter int          BaudRate  = 115200,
  parameter int          FifoDepth = 8,
  parameter logic [31:0] BaseAddr  = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        tx_o
);

  localparam int Div  = ClkFreq / BaudRate;
  localparam int CntW = $clog2(Div);
  localparam int FcW  = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  // ---------------------------------------------------------------- bus side
  logic          sel, is_write, is_data, is_status;
  logic          push_req, accept, push;
  logic [2:0]    off;
  logic [31:0]   status_w;
  logic [31:0]   rdata_d, rdata_q;
  logic          ready_d, ready_q;

  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_rdata;
  logic [FcW-1:0] fifo_count;

  tx_state_e      state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           baud_last;

  assign sel       = mem_valid_i && (mem_addr_i[31:3] == BaseAddr[31:3]);
  assign is_write  = |mem_wstrb_i;
  assign off       = {mem_addr_i[2], 2'b00};
  assign is_data   = (off == DataOff);
  assign is_status = (off == StatusOff);

  // Only a DATA write carrying byte lane 0 actually needs FIFO space; every
  // other selected request completes regardless of occupancy.
  assign push_req = sel && is_write && is_data && mem_wstrb_i[0];
  assign accept   = sel && !ready_q && !(push_req && fifo_full);
  assign push     = accept && push_req;

  always_comb begin
    status_w = '0;
    status_w[StatFullBit]  = fifo_full;
    status_w[StatEmptyBit] = fifo_empty;
    status_w[StatBusyBit]  = (state_q != IDLE);
    status_w[StatCountLsb +: FcW] = fifo_count;
  end

  assign ready_d = accept;
  assign rdata_d = (accept && !is_write && is_status) ? status_w : 32'h0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{mem_addr_i[1:0], mem_wdata_i[31:8]};

  // ------------------------------------------------------------------- FIFO
  fifo_1r1w_sync #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .wdata_i (mem_wdata_i[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ----------------------------------------------------------------- TX FSM
  assign baud_last = (baud_q == CntLast);

  // Pop from IDLE, or on the last STOP cycle so frames run back-to-back.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_last));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            state_q <= START;
            shift_q <= fifo_rdata;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            state_q <= DATA;
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              shift_q <= fifo_rdata;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o = tx_q;

endmodule
